led_randomizer: RTL and testbench

- Core of the hit-or-miss game: lights one of 8 LEDs at a pseudo-random position for a pseudo-random on-time, then waits a pseudo-random number of ticks before lighting the next one.
- Contains an internal tick divider (freq) and a 16-bit LFSR.
- Sits between the board clock and the LED pins.
- Exports the tick, the LED vector, the divider enable and the current on-time for the scoring logic.

---
 rtl/led_randomizer.sv | 176 +++++++++++++++++
 tb/tb_led_randomizer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_randomizer.sv
// -----------------------------------------------------------------------------
// led_randomizer
//
// Core of the hit-or-miss game. Lights one of eight LEDs at a pseudo-random
// position for a pseudo-random on-time. It then waits a pseudo-random number
// of divider ticks before lighting the next one.
//
// Parameters
//   TICK_DIV : clock cycles per freq tick (>= 1)
//   MIN_ON   : minimum LED on-time in cycles
//   DUR_STEP : cycles added per unit of random on-time (lfsr[15:8])
//   SEED     : LFSR reset value (nonzero)
//
// Ports
//   clk       in   1   system clock, all registers update on the rising edge
//   rst       in   1   synchronous reset, active-low (0 = reset)
//   freq      out  1   one-cycle tick from the internal divider
//   LED       out  8   one-hot LED drive, all zero when nothing is lit
//   enable_f  out  1   divider enable: 1 in WAIT, 0 in LIGHT
//   light_dur out  30  on-time in cycles of the current or most recent light
//
// Observing the FSM: the state is a single WAIT/LIGHT bit, and enable_f is
// its registered mirror (1 = WAIT, 0 = LIGHT). A checker can bind to
// enable_f, or to the internal 'state' signal.
//
// Build option
//   LED_NOREPEAT_EN : when defined, an index equal to the previously lit
//                     index is bumped to (index+1) mod 8. As a result, two
//                     consecutive lights never share an LED.
//
// Interface timing: there is no handshake. freq is a single-cycle strobe and
// LED/light_dur are plain registered levels.
// -----------------------------------------------------------------------------
module led_randomizer #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned MIN_ON   = 25000000,
    parameter int unsigned DUR_STEP = 98304,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        freq,
    output logic [7:0]  LED,
    output logic        enable_f,
    output logic [29:0] light_dur
);

    localparam logic [29:0] DIV_LAST   = 30'(TICK_DIV - 1);
    localparam logic [29:0] MIN_ON_W   = 30'(MIN_ON);
    localparam logic [29:0] DUR_STEP_W = 30'(DUR_STEP);

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_LIGHT = 1'b1
    } state_t;

    state_t      state;
    logic [29:0] div_cnt;     // tick divider, held at 0 while disabled
    logic [29:0] on_cnt;      // cycles elapsed in the current light
    logic [4:0]  wait_cnt;    // freq ticks still to wait, range 1..16
    logic [15:0] lfsr;

    // ------------------------------------------------------------------
    // Combinational decode of registered state
    // ------------------------------------------------------------------
    logic        lfsr_fb;
    logic [15:0] lfsr_next;
    logic        div_wrap;
    logic [2:0]  cand_idx;
    logic [2:0]  pick_idx;
    logic [7:0]  led_onehot;
    logic [29:0] dur_calc;
    logic [29:0] dur_eff;
    logic [4:0]  wait_reload;
    logic        light_last;

`ifdef LED_NOREPEAT_EN
    logic [2:0]  prev_idx;    // index of the most recent light
`endif

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1. The all-zero state is a
    // lock-up state for this structure, so it reseeds if it ever gets there.
    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign lfsr_next = (lfsr == 16'd0) ? SEED : {lfsr[14:0], lfsr_fb};

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign freq      = enable_f & div_wrap;

    assign cand_idx  = lfsr[2:0];

`ifdef LED_NOREPEAT_EN
    // The 3-bit add wraps 7 -> 0, which gives the mod-8 bump for free.
    assign pick_idx  = (cand_idx == prev_idx) ? cand_idx + 3'd1 : cand_idx;
`else
    assign pick_idx  = cand_idx;
`endif

    assign led_onehot = 8'd1 << pick_idx;

    // All arithmetic is 30 bits wide, so overflow simply truncates.
    // A zero result would never leave LIGHT, so it is promoted to 1.
    assign dur_calc    = MIN_ON_W + 30'(lfsr[15:8]) * DUR_STEP_W;
    assign dur_eff     = (dur_calc == 30'd0) ? 30'd1 : dur_calc;

    assign wait_reload = 5'd1 + {1'b0, lfsr[3:0]};

    // light_dur is always >= 1 while in LIGHT, so the subtraction cannot wrap.
    assign light_last  = (on_cnt == light_dur - 30'd1);

    // ------------------------------------------------------------------
    // Registers: divider, LFSR and the WAIT/LIGHT FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_WAIT;
            LED       <= 8'd0;
            enable_f  <= 1'b1;
            light_dur <= 30'd0;
            div_cnt   <= 30'd0;
            on_cnt    <= 30'd0;
            wait_cnt  <= 5'd1;
            lfsr      <= SEED;
`ifdef LED_NOREPEAT_EN
            prev_idx  <= 3'd0;
`endif
        end else begin
            lfsr <= lfsr_next;

            // The divider restarts from 0 on every return to WAIT. As a
            // result, the first tick after a light comes TICK_DIV cycles later.
            if (enable_f) begin
                div_cnt <= div_wrap ? 30'd0 : div_cnt + 30'd1;
            end else begin
                div_cnt <= 30'd0;
            end

            case (state)
                ST_WAIT: begin
                    if (freq) begin
                        if (wait_cnt == 5'd1) begin
                            // Capture position and on-time from the pre-shift
                            // LFSR value at this edge.
                            state     <= ST_LIGHT;
                            enable_f  <= 1'b0;
                            LED       <= led_onehot;
                            light_dur <= dur_eff;
                            on_cnt    <= 30'd0;
`ifdef LED_NOREPEAT_EN
                            prev_idx  <= pick_idx;
`endif
                        end else begin
                            wait_cnt <= wait_cnt - 5'd1;
                        end
                    end
                end

                ST_LIGHT: begin
                    on_cnt <= on_cnt + 30'd1;
                    if (light_last) begin
                        state    <= ST_WAIT;
                        enable_f <= 1'b1;
                        LED      <= 8'd0;
                        wait_cnt <= wait_reload;
                    end
                end

                default: begin
                    state    <= ST_WAIT;
                    enable_f <= 1'b1;
                    LED      <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_randomizer.sv
// -----------------------------------------------------------------------------
// tb_led_randomizer
//
// Directed bench for led_randomizer. It uses two instances that share clk/rst:
//   dut_a : TICK_DIV=4, MIN_ON=8, DUR_STEP=1  (reset, on-time, wait spacing)
//   dut_b : TICK_DIV=1, MIN_ON=1, DUR_STEP=0  (boundary, no-repeat run)
// A reference LFSR model (SEED 16'hACE1) supplies the expected index, on-time
// and wait count. The first light after reset is also checked against
// hand-computed constants:
//   SEED=ACE1 -> 59C3 -> B387 -> 670F. The dut_a first light uses 670F, so
//   LED=8'h80 and light_dur=8+0x67=111. The dut_b first light uses ACE1, so
//   LED=8'h02.
// -----------------------------------------------------------------------------
module tb_led_randomizer;

    `ifdef LED_NOREPEAT_EN
    localparam bit NOREPEAT = 1'b1;
    localparam int B_LIGHTS = 1000;
    `else
    localparam bit NOREPEAT = 1'b0;
    localparam int B_LIGHTS = 25;
    `endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        freq_a, en_a, freq_b, en_b;
    logic [7:0]  led_a, led_b;
    logic [29:0] dur_a, dur_b;

    led_randomizer #(.TICK_DIV(4), .MIN_ON(8), .DUR_STEP(1), .SEED(16'hACE1)) dut_a (
        .clk(clk), .rst(rst), .freq(freq_a), .LED(led_a),
        .enable_f(en_a), .light_dur(dur_a)
    );

    led_randomizer #(.TICK_DIV(1), .MIN_ON(1), .DUR_STEP(0), .SEED(16'hACE1)) dut_b (
        .clk(clk), .rst(rst), .freq(freq_b), .LED(led_b),
        .enable_f(en_b), .light_dur(dur_b)
    );

    // ---------------- reference LFSR model ----------------
    logic [15:0] m_lfsr, m_prev;   // m_prev = pre-shift value at the last edge

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v == 16'd0) return 16'hACE1;
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic logic [2:0] pick(input logic [2:0] cand, input logic [2:0] prev);
        return (NOREPEAT && cand == prev) ? cand + 3'd1 : cand;
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [2:0]  pa, pb;
    logic [7:0]  cur_led;
    logic [29:0] cur_dur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the negedge right after dut_a lit an LED.
    task automatic check_lit_a();
        logic [2:0] idx;
        idx = pick(m_prev[2:0], pa);
        check("lit_led", 32'(led_a), 32'(8'd1 << idx));
        check("lit_dur", 32'(dur_a), 32'(30'd8 + 30'(m_prev[15:8])));
        check("lit_en", 32'(en_a), 32'd0);
        pa      = idx;
        cur_led = 8'd1 << idx;
        cur_dur = 30'd8 + 30'(m_prev[15:8]);
    endtask

    // Reset release sequence for dut_a: freq only in cycle 4, then light.
    task automatic first_tick_a();
        for (int c = 1; c <= 4; c++) begin
            check("first_tick_freq", 32'(freq_a), (c == 4) ? 32'd1 : 32'd0);
            check("first_tick_led", 32'(led_a), 32'd0);
            tick();
        end
        check("first_led_hand", 32'(led_a), 32'h80);
        check("first_dur_hand", 32'(dur_a), 32'd111);
        check_lit_a();
    endtask

    // Follow n lights of dut_a from the lit negedge: on-time, wait spacing.
    task automatic follow_a(input int nlights);
        int cnt, bad, k, pulses, first_k;
        logic [4:0] w_exp;
        for (int i = 0; i < nlights; i++) begin
            cnt = 0;
            bad = 0;
            while (led_a != 8'd0 && cnt < 300) begin
                if (!$onehot(led_a) || en_a !== 1'b0 || freq_a !== 1'b0 || led_a !== cur_led) bad++;
                cnt++;
                tick();
            end
            check("on_time", 32'(cnt), 32'(cur_dur));
            check("light_clean", 32'(bad), 32'd0);

            w_exp   = 5'd1 + {1'b0, m_prev[3:0]};
            pulses  = 0;
            first_k = 0;
            bad     = 0;
            k       = 1;
            while (led_a == 8'd0 && k < 200) begin
                if (en_a !== 1'b1) bad++;
                if (freq_a) begin
                    pulses++;
                    if (first_k == 0) first_k = k;
                end
                k++;
                tick();
            end
            check("first_pulse", 32'(first_k), 32'd4);
            check("wait_pulses", 32'(pulses), 32'(w_exp));
            check("wait_clean", 32'(bad), 32'd0);
            check_lit_a();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lights, cyc, bad;
        logic prev_lit;
        logic [7:0] prev_led;
        logic [2:0] idx;

        rst = 1'b0;
        pa  = 3'd0;
        pb  = 3'd0;

        // Reset state over three reset edges.
        repeat (3) begin
            tick();
            check("rst_led", 32'(led_a), 32'd0);
            check("rst_en", 32'(en_a), 32'd1);
            check("rst_dur", 32'(dur_a), 32'd0);
            check("rst_freq", 32'(freq_a), 32'd0);
        end

        rst = 1'b1;
        first_tick_a();
        follow_a(6);

        // Reset in the middle of a light.
        tick();
        tick();
        tick();
        check("pre_rst_lit", 32'(led_a != 8'd0), 32'd1);
        rst = 1'b0;
        tick();
        check("midrst_led", 32'(led_a), 32'd0);
        check("midrst_en", 32'(en_a), 32'd1);
        check("midrst_dur", 32'(dur_a), 32'd0);
        pa  = 3'd0;
        rst = 1'b1;
        first_tick_a();
        follow_a(2);

        // Boundary instance: fresh reset, then every WAIT cycle ticks and
        // every light lasts one cycle.
        rst = 1'b0;
        tick();
        tick();
        rst      = 1'b1;
        pb       = 3'd0;
        lights   = 0;
        cyc      = 0;
        bad      = 0;
        prev_lit = 1'b0;
        prev_led = 8'd0;
        while (lights < B_LIGHTS && cyc < B_LIGHTS * 20 + 50) begin
            if (led_b != 8'd0) begin
                idx = pick(m_prev[2:0], pb);
                check("b_led", 32'(led_b), 32'(8'd1 << idx));
                check("b_dur", 32'(dur_b), 32'd1);
                check("b_one_cycle", 32'(prev_lit), 32'd0);
                if (en_b !== 1'b0 || freq_b !== 1'b0) bad++;
                if (lights == 0) check("b_first_led_hand", 32'(led_b), 32'h02);
                `ifdef LED_NOREPEAT_EN
                if (lights == 0) check("b_first_not_led0", 32'(led_b[0]), 32'd0);
                else             check("b_norepeat", 32'(led_b == prev_led), 32'd0);
                `endif
                pb       = idx;
                prev_led = led_b;
                prev_lit = 1'b1;
                lights++;
            end else begin
                if (freq_b !== 1'b1 || en_b !== 1'b1) bad++;
                prev_lit = 1'b0;
            end
            cyc++;
            tick();
        end
        check("b_lights", 32'(lights), 32'(B_LIGHTS));
        check("b_state_clean", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
